// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU memory bus target.
//
// Holds the bus data/address widths, the offsets of the four
// memory-mapped I/O registers relative to IO_BASE, and the state
// encoding of the host program-loader FSM.
package cpu_bus_pkg;

  localparam int BUS_DW = 8;
  localparam int BUS_AW = 8;

  localparam logic [1:0] IO_OUT  = 2'd0;
  localparam logic [1:0] IO_IN   = 2'd1;
  localparam logic [1:0] IO_TMR  = 2'd2;
  localparam logic [1:0] IO_STAT = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } loader_state_e;

endpackage

// File: rtl/bus_io_regs.sv
// Memory-mapped I/O register block of the bus responder.
//
// Owns the output port register, the io_in synchronizer, the free-running
// timer with its prescaler, and the sticky overflow status flag. Returns
// the read data for whichever I/O offset is addressed.
//
// Optional feature macro: BUS_RESPONDER_TIMER_EN. When it is undefined no
// timer hardware exists and the timer/status offsets read as zero.
//
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   wr_i      CPU write to an I/O address this cycle
//   rd_i      CPU read of an I/O address this cycle
//   offset_i  register offset (addr - IO_BASE)
//   wdata_i   CPU write data
//   io_in_i   asynchronous input port
//   io_out_o  output port register
//   rdata_o   read data for the addressed offset (combinational)
import cpu_bus_pkg::*;

module bus_io_regs #(
  parameter int TIMER_PRESCALE = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [1:0]        offset_i,
  input  logic [BUS_DW-1:0] wdata_i,
  input  logic [BUS_DW-1:0] io_in_i,
  output logic [BUS_DW-1:0] io_out_o,
  output logic [BUS_DW-1:0] rdata_o
);

  logic [BUS_DW-1:0] io_out_q;
  logic [BUS_DW-1:0] sync_q [SYNC_STAGES];

  // Output port register, written only through its own offset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      io_out_q <= '0;
    end else if (wr_i && (offset_i == IO_OUT)) begin
      io_out_q <= wdata_i;
    end
  end

  // Plain flop chain to bring the asynchronous input port into clk_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= io_in_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign io_out_o = io_out_q;

`ifdef BUS_RESPONDER_TIMER_EN
  logic [15:0] presc_q, presc_d;
  logic [7:0]  count_q, count_d;
  logic        ovf_q, ovf_d;

  // Timer next state. The ovf clear on a status read is applied before
  // the overflow set so that a coincident overflow keeps the flag high.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (rd_i && (offset_i == IO_STAT)) begin
      ovf_d = 1'b0;
    end
    if (wr_i && (offset_i == IO_TMR)) begin
      presc_d = '0;
      count_d = '0;
    end else if (presc_q == 16'(TIMER_PRESCALE - 1)) begin
      presc_d = '0;
      count_d = count_q + 8'd1;
      if (count_q == 8'hFF) begin
        ovf_d = 1'b1;
      end
    end else begin
      presc_d = presc_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
`else
  // Without the timer the read strobe and prescale setting have no use.
  logic unused_rd;
  assign unused_rd = rd_i;
  localparam int unused_prescale = TIMER_PRESCALE;
`endif

  // Read mux for the I/O window.
  always_comb begin
    rdata_o = '0;
    case (offset_i)
      IO_OUT:  rdata_o = io_out_q;
      IO_IN:   rdata_o = sync_q[SYNC_STAGES-1];
`ifdef BUS_RESPONDER_TIMER_EN
      IO_TMR:  rdata_o = count_q;
      IO_STAT: rdata_o = {7'b0, ovf_q};
`endif
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/bus_responder.sv
// Target end of the CPU memory bus.
//
// Serves CPU reads/writes from a program/data RAM below IO_BASE and four
// memory-mapped I/O registers at IO_BASE..8'hFF. A host program loader
// fills the RAM through a valid/ready byte stream while holding the CPU
// off the bus.
//
// Optional feature macro: BUS_RESPONDER_TIMER_EN (timer + overflow flag
// in the I/O block).
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   addr, data_in       CPU address and write data
//   rden, wren          CPU read / write strobes
//   data_out            registered read data (1-edge latency)
//   load_start          pulse that starts (or restarts) a program load
//   load_valid/data     host byte stream
//   load_ready          responder accepts a byte this cycle
//   load_end            host pulse ending the load early
//   cpu_hold            high while a load is in progress
//   io_out, io_in       output port register, asynchronous input port
import cpu_bus_pkg::*;

module bus_responder #(
  parameter logic [7:0] IO_BASE        = 8'hFC,
  parameter int         TIMER_PRESCALE = 16,
  parameter int         SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  addr,
  input  logic [7:0]  data_in,
  input  logic        rden,
  input  logic        wren,
  output logic [7:0]  data_out,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  output logic        load_ready,
  input  logic        load_end,
  output logic        cpu_hold,
  output logic [7:0]  io_out,
  input  logic [7:0]  io_in
);

  localparam int         RAM_DEPTH = int'(IO_BASE);
  localparam logic [7:0] LAST_PTR  = IO_BASE - 8'd1;

  loader_state_e state_q, state_d;
  logic [7:0]    ptr_q, ptr_d;
  logic [7:0]    data_out_q, data_out_d;
  logic [7:0]    ram_q [RAM_DEPTH];

  logic          is_io;
  logic          cpu_rd;
  logic          cpu_wr;
  logic          ram_we;
  logic [7:0]    ram_waddr;
  logic [7:0]    ram_wdata;
  logic [1:0]    io_off;
  logic [7:0]    io_rdata;

  // The CPU owns the bus only in IDLE. A simultaneous read and write is
  // treated as a write alone, so the read side (and its clear-on-read
  // effect on the status flag) is suppressed.
  assign is_io  = (addr >= IO_BASE);
  assign io_off = 2'(addr - IO_BASE);
  assign cpu_wr = (state_q == IDLE) && wren;
  assign cpu_rd = (state_q == IDLE) && rden && !wren;

  // Loader next state and RAM write-port steering. Acceptance of the byte
  // at the last RAM address ends the load so the pointer never enters the
  // I/O window; a byte arriving with load_end is still written.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ram_we    = cpu_wr && !is_io;
    ram_waddr = addr;
    ram_wdata = data_in;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          ram_we    = 1'b1;
          ram_waddr = ptr_q;
          ram_wdata = load_data;
          ptr_d     = ptr_q + 8'd1;
        end
        if (load_start) begin
          ptr_d = '0;
        end
        if (load_end || (load_valid && (ptr_q == LAST_PTR))) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data only changes on an accepted CPU read.
  always_comb begin
    data_out_d = data_out_q;
    if (cpu_rd) begin
      data_out_d = is_io ? io_rdata : ram_q[addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      data_out_q <= data_out_d;
    end
  end

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_waddr] <= ram_wdata;
    end
  end

  // Hold and ready are decoded from the state flop, so they rise on the
  // entry edge, fall together on the exit edge and drop with reset.
  assign cpu_hold   = (state_q == LOAD);
  assign load_ready = (state_q == LOAD);
  assign data_out   = data_out_q;

  bus_io_regs #(
    .TIMER_PRESCALE (TIMER_PRESCALE),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_io_regs (
    .clk_i    (clk),
    .rst_ni   (rst),
    .wr_i     (cpu_wr && is_io),
    .rd_i     (cpu_rd && is_io),
    .offset_i (io_off),
    .wdata_i  (data_in),
    .io_in_i  (io_in),
    .io_out_o (io_out),
    .rdata_o  (io_rdata)
  );

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder. Expected read data is queued
// when a read is issued and popped when the registered result appears.
module tb_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic       rden;
  logic       wren;
  logic [7:0] data_out;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_end;
  logic       cpu_hold;
  logic [7:0] io_out;
  logic [7:0] io_in;

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  logic [7:0] expQ [$];

  always #5 clk = ~clk;

  bus_responder #(
    .IO_BASE        (8'hFC),
    .TIMER_PRESCALE (1),
    .SYNC_STAGES    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .data_in    (data_in),
    .rden       (rden),
    .wren       (wren),
    .data_out   (data_out),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_end   (load_end),
    .cpu_hold   (cpu_hold),
    .io_out     (io_out),
    .io_in      (io_in)
  );

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one CPU bus cycle across a rising edge, then release strobes.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    rden    = rd;
    wren    = wr;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
    rden = 1'b0;
    wren = 1'b0;
  endtask

  // Read through the scoreboard queue.
  task automatic cpuRead(input string tag, input logic [7:0] a, input logic [7:0] exp);
    expQ.push_back(exp);
    applyStimulus(1'b1, 1'b0, a, 8'h00);
    checkOutput(tag, data_out, expQ.pop_front());
  endtask

  // One loader-side cycle.
  task automatic loaderCycle(input logic st, input logic vld, input logic [7:0] d, input logic en);
    load_start = st;
    load_valid = vld;
    load_data  = d;
    load_end   = en;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_end   = 1'b0;
  endtask

  initial begin
    logic [7:0] tmrExp;
    rst = 1'b0; addr = 8'h00; data_in = 8'h00; rden = 1'b0; wren = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_end = 1'b0;
    io_in = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_data_out", data_out, 8'h00);
    checkOutput("rst_io_out", io_out, 8'h00);
    checkOutput("rst_load_ready", {7'b0, load_ready}, 8'h00);
    checkOutput("rst_cpu_hold", {7'b0, cpu_hold}, 8'h00);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic RAM write/read
    $display("[TB] RAM write/read");
    applyStimulus(1'b0, 1'b1, 8'h10, 8'hA5);
    checkOutput("data_out_before_read", data_out, 8'h00);
    cpuRead("ram_10_a5", 8'h10, 8'hA5);
    applyStimulus(1'b1, 1'b1, 8'h10, 8'h77);
    checkOutput("rdwr_holds_data_out", data_out, 8'hA5);
    cpuRead("ram_10_77", 8'h10, 8'h77);

    // Short load with gaps and early end
    $display("[TB] short load");
    applyStimulus(1'b0, 1'b1, 8'h05, 8'h55);
    checkOutput("hold_low_idle", {7'b0, cpu_hold}, 8'h00);
    loaderCycle(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("hold_high_load", {7'b0, cpu_hold}, 8'h01);
    checkOutput("ready_high_load", {7'b0, load_ready}, 8'h01);
    loaderCycle(1'b0, 1'b1, 8'h11, 1'b0);
    loaderCycle(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h05, 8'hEE);
    loaderCycle(1'b0, 1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h10, 8'h00);
    checkOutput("load_read_ignored", data_out, 8'h77);
    loaderCycle(1'b0, 1'b1, 8'h33, 1'b0);
    checkOutput("hold_still_high", {7'b0, cpu_hold}, 8'h01);
    loaderCycle(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("hold_low_after_end", {7'b0, cpu_hold}, 8'h00);
    checkOutput("ready_low_after_end", {7'b0, load_ready}, 8'h00);
    cpuRead("ram_0", 8'h00, 8'h11);
    cpuRead("ram_1", 8'h01, 8'h22);
    cpuRead("ram_2", 8'h02, 8'h33);
    cpuRead("ram_5_untouched", 8'h05, 8'h55);

    // Full-RAM load terminates at the last RAM byte
    $display("[TB] full load");
    applyStimulus(1'b0, 1'b1, 8'hFC, 8'hC3);
    loaderCycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 252; i++) begin
      loaderCycle(1'b0, 1'b1, 8'(i) ^ 8'h5A, 1'b0);
      if (i == 250) checkOutput("hold_before_last", {7'b0, cpu_hold}, 8'h01);
    end
    checkOutput("full_hold_low", {7'b0, cpu_hold}, 8'h00);
    checkOutput("full_ready_low", {7'b0, load_ready}, 8'h00);
    checkOutput("full_io_out_kept", io_out, 8'hC3);
    cpuRead("full_ram_00", 8'h00, 8'h5A);
    cpuRead("full_ram_10", 8'h10, 8'h4A);
    cpuRead("full_ram_fb", 8'hFB, 8'hA1);
    cpuRead("full_io_out_read", 8'hFC, 8'hC3);

    // I/O output and input synchronizer latency
    $display("[TB] io ports");
    applyStimulus(1'b0, 1'b1, 8'hFC, 8'h3C);
    checkOutput("io_out_3c", io_out, 8'h3C);
    io_in = 8'h5A;
    cpuRead("io_in_edge1", 8'hFD, 8'h00);
    cpuRead("io_in_edge2", 8'hFD, 8'h00);
    cpuRead("io_in_edge3", 8'hFD, 8'h5A);
    applyStimulus(1'b0, 1'b1, 8'hFD, 8'hFF);
    cpuRead("io_in_ro", 8'hFD, 8'h5A);

    // Timer overflow and clear-on-read status
    $display("[TB] timer");
`ifdef BUS_RESPONDER_TIMER_EN
    tmrExp = 8'h01;
`else
    tmrExp = 8'h00;
`endif
    applyStimulus(1'b0, 1'b1, 8'hFE, 8'h00);
    repeat (256) @(posedge clk);
    #1;
    cpuRead("status_ovf", 8'hFF, tmrExp);
    cpuRead("status_cleared", 8'hFF, 8'h00);

    // Reset in the middle of a load
    $display("[TB] reset mid-load");
    cpuRead("pre_reset_read", 8'h10, 8'h4A);
    loaderCycle(1'b1, 1'b0, 8'h00, 1'b0);
    loaderCycle(1'b0, 1'b1, 8'h9A, 1'b0);
    loaderCycle(1'b0, 1'b1, 8'hBC, 1'b0);
    checkOutput("midload_hold", {7'b0, cpu_hold}, 8'h01);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_hold_low", {7'b0, cpu_hold}, 8'h00);
    checkOutput("async_ready_low", {7'b0, load_ready}, 8'h00);
    checkOutput("async_data_out", data_out, 8'h00);
    checkOutput("async_io_out", io_out, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cpuRead("kept_ram_0", 8'h00, 8'h9A);
    cpuRead("kept_ram_1", 8'h01, 8'hBC);
    cpuRead("kept_ram_2", 8'h02, 8'h02 ^ 8'h5A);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Target end of the CPU memory bus. Answers the CPU's addr/rden/wren accesses from a 252-byte program/data RAM and four memory-mapped I/O registers.
- Contains a host program-loader FSM. The loader fills RAM through a valid/ready byte stream while holding the CPU off the bus.
- Sits between the cpu block and the board top level, replacing the bare RAM instance.

Parameters:
- IO_BASE, 8'hFC, first I/O address; addresses IO_BASE..8'hFF are I/O and everything below is RAM.
- TIMER_PRESCALE, 16, clk cycles per timer tick; legal range 1..65535.
- SYNC_STAGES, 2, flop stages on io_in; legal range 2..3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; rst=0 resets all state.
- addr  in  8  CPU bus address.
- data_in  in  8  CPU write data.
- rden  in  1  CPU read strobe.
- wren  in  1  CPU write strobe.
- data_out  out  8  read data returned to the CPU.
- load_start  in  1  one-cycle pulse that begins a program load.
- load_valid  in  1  host byte valid.
- load_data  in  8  host byte.
- load_ready  out  1  responder accepts the byte this cycle.
- load_end  in  1  host pulse that terminates the load early.
- cpu_hold  out  1  high while loading; drives the cpu halt/run gating.
- io_out  out  8  output port register.
- io_in  in  8  asynchronous input port.

Behaviour:
- Reset (rst=0, asynchronous):
  - data_out=0, io_out=0, load_ready=0, cpu_hold=0.
  - Loader state=IDLE, load pointer=0, timer=0, ovf flag=0, synchronizer flops=0.
  - RAM contents are not reset.
- CPU read, accepted only in IDLE:
  - On the rising edge with rden=1, data_out <= the selected source. Latency is 1 edge, so the CPU samples on the following falling edge.
  - data_out holds its value on every cycle without a read.
- CPU write, accepted only in IDLE:
  - On the rising edge with wren=1, the target RAM byte or I/O register is written.
  - If rden=1 and wren=1 together, the write is performed and data_out holds its value.
- Address decode:
  - addr < IO_BASE: RAM[addr].
  - IO_BASE+0: io_out. Read/write.
  - IO_BASE+1: synchronized io_in. Read-only; writes are ignored.
  - IO_BASE+2: timer count. Read returns the count. Any write clears the count and the prescaler.
  - IO_BASE+3: status = {7'b0, ovf}. A read returns ovf and then clears it. Writes are ignored.
- Timer:
  - The prescaler counts 0..TIMER_PRESCALE-1.
  - At the wrap, the 8-bit count increments mod 256.
  - At the count transition 255->0, ovf is set (sticky).
  - If a set and a clearing status read occur in the same cycle, the set wins and ovf stays 1.
- Loader FSM, states IDLE, LOAD:
  - IDLE -> LOAD on load_start=1. Pointer <= 0 and cpu_hold <= 1 on that edge.
  - In LOAD:
    - load_ready=1 (registered, asserted from the first LOAD cycle).
    - When load_valid & load_ready: RAM[pointer] <= load_data and pointer++.
    - CPU rden/wren are ignored and data_out holds its value.
  - LOAD -> IDLE on load_end=1, or on acceptance of the byte at pointer IO_BASE-1 (RAM full). The full-RAM case never wraps into I/O space.
  - On the exit edge, cpu_hold and load_ready drop together.
  - If load_end and load_valid occur in the same cycle, the byte is accepted first and then the FSM exits.
  - load_start while in LOAD restarts the pointer at 0.
- Reset mid-load: returns to IDLE immediately. Bytes already written stay in RAM.
- Width rules:
  - The pointer is 8-bit and is compared against IO_BASE-1.
  - The timer count wraps at 8 bits. The prescaler is 16-bit.

Optional Feature:
- Macro BUS_RESPONDER_TIMER_EN.
- Defined: the timer, prescaler and ovf flag exist exactly as specified above.
- Undefined: no timer logic is synthesized. Reads of IO_BASE+2 and IO_BASE+3 return 8'h00, and writes to them are ignored.

Decomposition:
- Shared package (cpu_bus_pkg) holds:
  - I/O offset constants: IO_OUT=0, IO_IN=1, IO_TMR=2, IO_STAT=3.
  - Loader state encoding: IDLE, LOAD.
  - The 8-bit bus data/address widths.
- One natural sub-module: bus_io_regs. It owns io_out, the io_in synchronizer, the timer and the status register, and returns the read mux for I/O addresses.
- The RAM array and the loader FSM stay in bus_responder.

Test Plan:
1. Reset release, then wren at addr 8'h10 with data 8'hA5, then rden at 8'h10 -> data_out=8'hA5 one edge after the read; data_out=0 before any read.
2. load_start, then stream 3 bytes 8'h11,8'h22,8'h33 with load_valid gaps, then load_end -> RAM[0..2]=11,22,33; cpu_hold high exactly during LOAD; a CPU wren at 8'h05 issued during LOAD leaves RAM[5] unchanged.
3. Stream 252 bytes with no load_end -> FSM returns to IDLE after the byte at 8'hFB; io_out is unchanged; load_ready=0 the following cycle.
4. Write 8'h3C to 8'hFC -> io_out=8'h3C; drive io_in=8'h5A -> a read of 8'hFD returns 8'h5A no earlier than SYNC_STAGES edges after io_in changes.
5. BUS_RESPONDER_TIMER_EN defined, TIMER_PRESCALE=1: write 8'hFE, wait 256 cycles -> read 8'hFF returns 8'h01, and a second read returns 8'h00. Macro undefined: both reads return 8'h00.
6. Drive rst=0 in the middle of a LOAD -> cpu_hold and load_ready fall asynchronously and data_out=0; bytes written before the reset remain readable after it.
